// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC and instruction-memory request sequencer for the
// three-pipe VLIW front end. Issues one word request per cycle over a
// req/ack handshake, redirects on taken branches and holds pipe_flush high
// for FLUSH_CYCLES cycles after each redirect.
// Optional build macro: FETCH_SEQ_PERF_EN adds saturating perf_words and
// perf_stalls counters.
module fetch_sequencer #(
  parameter int unsigned           PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]   START_ADDR   = '0,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                halt,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  output logic                f_flush,
  output logic                pipe_flush,
  output logic                busy,
  output logic [PC_WIDTH-1:0] pc
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]         perf_words,
  output logic [15:0]         perf_stalls
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // Counter runs FLUSH_CYCLES-1 .. 0, giving FLUSH_CYCLES redirect cycles.
  localparam logic [3:0]          CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);

  state_t              state;
  state_t              state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [3:0]          cnt;
  logic [3:0]          cnt_next;
  logic                accept;

  // State, PC and redirect counter registers; pipe_flush mirrors the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= START_ADDR;
      cnt        <= '0;
      pipe_flush <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      cnt        <= cnt_next;
      pipe_flush <= (state_next == REDIRECT);
    end
  end

  // Next-state, next-PC and handshake decode; branch beats halt beats stall.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cnt;
    imem_req   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = START_ADDR;
        end
      end
      FETCH: begin
        imem_req = ~stall;
        // A word that arrives alongside a branch belongs to the wrong path.
        accept   = imem_req & imem_ack & ~branch_taken;
        if (branch_taken) begin
          state_next = REDIRECT;
          pc_next    = branch_target;
          cnt_next   = CNT_LOAD;
        end else begin
          if (accept) begin
            pc_next = pc + PC_ONE;
          end
          if (halt) begin
            state_next = IDLE;
          end
        end
      end
      REDIRECT: begin
        if (branch_taken) begin
          pc_next  = branch_target;
          cnt_next = CNT_LOAD;
        end else if (cnt == 4'd0) begin
          state_next = halt ? IDLE : FETCH;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign f_flush   = ~accept;
  assign busy      = (state != IDLE);
  assign imem_addr = pc;

`ifdef FETCH_SEQ_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // Saturating performance counters, cleared by reset and by a start from IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_words  <= '0;
      perf_stalls <= '0;
    end else if (state == IDLE && start) begin
      perf_words  <= '0;
      perf_stalls <= '0;
    end else begin
      if (accept) begin
        perf_words <= sat_inc(perf_words);
      end
      if (state == FETCH && stall) begin
        perf_stalls <= sat_inc(perf_stalls);
      end
    end
  end
`endif

endmodule
